// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in / parallel-out deserializer.
// Holds the FSM state enum, the bit-counter width helper and the parity-bit count.
// Build option: define SIPO_PARITY_EN to append one even-parity bit to every word.
package sipo_pkg;

    // COMPLETE marks the cycle whose edge accepts the last bit of a word;
    // it is decoded combinationally and never held in the state register.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        COMPLETE = 2'd2
    } state_e;

`ifdef SIPO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Width of a counter that must hold the values 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter: assembles WIDTH serial bits (and an optional
// trailing parity bit) and pulses word_done on the edge that accepts the final bit.
// Ports: clk/reset/clr control; sin_valid/sin serial input; word is the assembled
// word including the bit accepted this cycle; word_done qualifies it; bit_cnt is
// the number of bits taken so far in the current word.
// Build option: SIPO_PARITY_EN (via sipo_pkg::PAR_BITS) extends the word by one bit.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        sin_valid,
    input  logic                        sin,
    output logic [WIDTH-1:0]            word,
    output logic                        word_done,
    output logic [cnt_w(WIDTH)-1:0]     bit_cnt
);

    localparam int              CW      = cnt_w(WIDTH);
    localparam int              LAST    = WIDTH + PAR_BITS;
    localparam logic [CW-1:0]   LAST_M1 = CW'(LAST - 1);
    localparam logic [CW-1:0]   DATA_N  = CW'(WIDTH);
    localparam logic [CW-1:0]   ONE     = CW'(1);

    state_e             state_q;
    state_e             state_nxt;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   q_d;
    logic [WIDTH-1:0]   q_shifted;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               data_bit;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign q_shifted = {sin, q[WIDTH-1:1]};
        end else begin : g_msb_first
            assign q_shifted = {q[WIDTH-2:0], sin};
        end
    endgenerate

    // Positions 0..WIDTH-1 carry data; the optional parity bit sits at
    // position WIDTH and must not disturb the assembled word.
    assign data_bit = (cnt_q < DATA_N);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (sin_valid) state_nxt = SHIFT;
            SHIFT:   if (sin_valid && (cnt_q == LAST_M1)) state_nxt = COMPLETE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word_done = (state_nxt == COMPLETE);
        q_d       = q;
        cnt_d     = cnt_q;
        if (sin_valid && data_bit) begin
            q_d = q_shifted;
        end
        if (word_done) begin
            cnt_d = '0;
        end else if (sin_valid) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // The word is taken from the next-state value so the final data bit is
    // visible on the same edge that accepts it.
    assign word    = q_d;
    assign bit_cnt = cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            q       <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            state_q <= IDLE;
            q       <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= (state_nxt == COMPLETE) ? IDLE : state_nxt;
            q       <= q_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a registered, double-buffered output
// word and valid/ready handshake; dout_valid rises on the edge accepting the last bit.
// Ports: clk, reset (async active-low), clr (sync clear); sin_valid/sin serial in;
// dout/dout_valid/dout_ready parallel out; busy, bit_cnt status; overrun sticky drop flag.
// Build option: SIPO_PARITY_EN adds a trailing even-parity bit per word and the
// parity_err output, loaded and held together with dout.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        sin_valid,
    input  logic                        sin,
    output logic [WIDTH-1:0]            dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        busy,
    output logic [cnt_w(WIDTH)-1:0]     bit_cnt,
    output logic                        overrun
`ifdef SIPO_PARITY_EN
    ,
    output logic                        parity_err
`endif
);

    logic [WIDTH-1:0]   word;
    logic               word_done;
    logic               load;
    logic               drop;
    logic               consume;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .sin_valid (sin_valid),
        .sin       (sin),
        .word      (word),
        .word_done (word_done),
        .bit_cnt   (bit_cnt)
    );

    assign busy = (bit_cnt != '0);

    // A finished word may enter the buffer if it is empty or being drained on
    // this same edge; otherwise the new word is lost and overrun latches.
    assign consume = dout_valid && dout_ready;
    assign load    = word_done && (!dout_valid || dout_ready);
    assign drop    = word_done && dout_valid && !dout_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (clr) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                dout       <= word;
                dout_valid <= 1'b1;
            end else if (consume) begin
                dout_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // On completion the bit on sin is the parity bit itself, so the even-parity
    // check covers the stored word plus that bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if (clr) begin
            parity_err <= 1'b0;
        end else if (load) begin
            parity_err <= (^word) ^ sin;
        end
    end
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int WLEN = W + 1;
`else
    localparam int WLEN = W;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clr = 1'b0;
    logic sin_valid = 1'b0;
    logic sin = 1'b0;
    logic dout_ready = 1'b0;

    logic [W-1:0] dout_l, dout_m;
    logic         dv_l, dv_m, busy_l, busy_m, ov_l, ov_m;
    logic [2:0]   cnt_l, cnt_m;
`ifdef SIPO_PARITY_EN
    logic         pe_l, pe_m;
`endif

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .clr(clr), .sin_valid(sin_valid), .sin(sin),
        .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
        .busy(busy_l), .bit_cnt(cnt_l), .overrun(ov_l)
`ifdef SIPO_PARITY_EN
        , .parity_err(pe_l)
`endif
    );

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .clr(clr), .sin_valid(sin_valid), .sin(sin),
        .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
        .busy(busy_m), .bit_cnt(cnt_m), .overrun(ov_m)
`ifdef SIPO_PARITY_EN
        , .parity_err(pe_m)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: bits of the word in flight, buffer occupancy, sticky drop
    // flag, and scoreboards of words expected at each output ({perr, word}).
    logic       mbits[$];
    logic [W:0] exp_l[$];
    logic [W:0] exp_m[$];
    bit         occ = 1'b0;
    bit         ov  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_clear();
        mbits.delete();
        exp_l.delete();
        exp_m.delete();
        occ = 1'b0;
        ov  = 1'b0;
    endfunction

    function automatic void model_step(input logic sv, input logic s, input logic rdy, input logic c);
        logic [W-1:0] wl, wm;
        logic         p;
        bit           done;
        if (c) begin
            model_clear();
            return;
        end
        done = 1'b0;
        wl = '0;
        wm = '0;
        p  = 1'b0;
        if (sv) begin
            mbits.push_back(s);
            if (mbits.size() == WLEN) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) begin
                    wl[i]       = mbits[i];
                    wm[W-1-i]   = mbits[i];
                end
`ifdef SIPO_PARITY_EN
                for (int i = 0; i < WLEN; i++) p = p ^ mbits[i];
`endif
                mbits.delete();
            end
        end
        if (done) begin
            if (!occ || rdy) begin
                occ = 1'b1;
                exp_l.push_back({p, wl});
                exp_m.push_back({p, wm});
            end else begin
                ov = 1'b1;
            end
        end else if (occ && rdy) begin
            occ = 1'b0;
        end
    endfunction

    task automatic cyc(input logic sv, input logic s, input logic rdy, input logic c);
        sin_valid  = sv;
        sin        = s;
        dout_ready = rdy;
        clr        = c;
        @(posedge clk);
        if (reset) model_step(sv, s, rdy, c);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_clear();
        sin_valid = 1'b0;
        clr = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Send one word bit 0 first; rdy applies to all bits but the last,
    // rdy_last to the final one; gap idle cycles follow the first bit.
    task automatic send(input logic [W:0] wbits, input logic rdy, input logic rdy_last, input int gap);
        logic [W:0] tmp;
        tmp = wbits;
        for (int i = 0; i < WLEN; i++) begin
            cyc(1'b1, tmp[i], (i == WLEN - 1) ? rdy_last : rdy, 1'b0);
            if (i == 0) repeat (gap) cyc(1'b0, 1'b0, rdy, 1'b0);
        end
    endtask

    function automatic logic [W:0] pw(input logic [W-1:0] d, input logic bad);
        return {(^d) ^ bad, d};
    endfunction

    // Monitor: samples mid-cycle, compares status every cycle and pops the
    // scoreboard whenever a handshake is about to take place.
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            chk("dout_valid_lsb", {31'd0, dv_l}, {31'd0, occ});
            chk("dout_valid_msb", {31'd0, dv_m}, {31'd0, occ});
            chk("overrun_lsb", {31'd0, ov_l}, {31'd0, ov});
            chk("overrun_msb", {31'd0, ov_m}, {31'd0, ov});
            chk("bit_cnt_lsb", {29'd0, cnt_l}, mbits.size());
            chk("bit_cnt_msb", {29'd0, cnt_m}, mbits.size());
            chk("busy_lsb", {31'd0, busy_l}, {31'd0, (mbits.size() != 0)});
            chk("busy_msb", {31'd0, busy_m}, {31'd0, (mbits.size() != 0)});
            if (dv_l && dout_ready) begin
                if (exp_l.size() == 0) begin
                    chk("unexpected_word_lsb", {28'd0, dout_l}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_l.pop_front();
                    chk("dout_lsb", {28'd0, dout_l}, {28'd0, e[W-1:0]});
`ifdef SIPO_PARITY_EN
                    chk("parity_err_lsb", {31'd0, pe_l}, {31'd0, e[W]});
`endif
                end
            end
            if (dv_m && dout_ready) begin
                if (exp_m.size() == 0) begin
                    chk("unexpected_word_msb", {28'd0, dout_m}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_m.pop_front();
                    chk("dout_msb", {28'd0, dout_m}, {28'd0, e[W-1:0]});
`ifdef SIPO_PARITY_EN
                    chk("parity_err_msb", {31'd0, pe_m}, {31'd0, e[W]});
`endif
                end
            end
        end
    end

    initial begin
        int r;
        do_reset(2);

        // Basic word 1,0,1,1 with ready held high.
        send(pw(4'b1101, 1'b0), 1'b1, 1'b1, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Gap of three idle cycles after the first bit.
        send(pw(4'hF, 1'b0), 1'b1, 1'b1, 3);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Consumer stalled: second word dropped, overrun sticky until clr.
        send(pw(4'h5, 1'b0), 1'b0, 1'b0, 0);
        send(pw(4'hA, 1'b0), 1'b0, 1'b0, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Completion coinciding with ready on a pending word.
        send(pw(4'h9, 1'b0), 1'b0, 1'b0, 0);
        send(pw(4'h3, 1'b0), 1'b0, 1'b1, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a word, then a fresh word (and bad parity).
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        do_reset(2);
        send(pw(4'h6, 1'b0), 1'b1, 1'b1, 0);
        send(pw(4'h6, 1'b1), 1'b1, 1'b1, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Clear mid-word discards the bit presented with it.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        send(pw(4'hC, 1'b0), 1'b1, 1'b1, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic with occasional clr and reset.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 499);
            if (r == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
            end
        end

        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("scoreboard_drained_lsb", exp_l.size(), 0);
        chk("scoreboard_drained_msb", exp_m.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
